// File: rtl/seq_multiplier_if.sv
// Handshake/operand bundle between the core control FSM (master) and seq_multiplier (slave).
interface seq_multiplier_if #(
  parameter int WIDTH = 32
);
  logic             enable;
  logic             start;
  logic [1:0]       mode;
  logic [WIDTH-1:0] operand_1;
  logic [WIDTH-1:0] operand_2;
  logic [WIDTH-1:0] result;
  logic             busy;
  logic             done;

  modport master (
    output enable, start, mode, operand_1, operand_2,
    input  result, busy, done
  );

  modport slave (
    input  enable, start, mode, operand_1, operand_2,
    output result, busy, done
  );
endinterface

// File: rtl/seq_multiplier.sv
// Multicycle shift-add multiplier for MUL/MULH/MULHSU/MULHU with start/busy/done handshake.
// Optional macro SEQ_MUL_EARLY_OUT_EN ends the add loop once the remaining multiplier bits are zero.
module seq_multiplier #(
  parameter int WIDTH = 32
) (
  input logic             clk,
  input logic             rst,
  seq_multiplier_if.slave bus
);
  localparam int CNT_W = $clog2(WIDTH + 1);

  typedef enum logic [1:0] {
    S_IDLE,
    S_CALC,
    S_FIX,
    S_DONE
  } state_t;

  state_t               state_q, state_d;
  logic [1:0]           mode_q, mode_d;
  logic [2*WIDTH-1:0]   acc_q, acc_d;
  logic [2*WIDTH-1:0]   mcand_q, mcand_d;
  logic [WIDTH-1:0]     mplier_q, mplier_d;
  logic [CNT_W-1:0]     count_q, count_d;
  logic                 neg_q, neg_d;
  logic [WIDTH-1:0]     result_q, result_d;
  logic                 busy_q, busy_d;
  logic                 done_q, done_d;

  logic                 op1_neg, op2_neg;
  logic [WIDTH-1:0]     op1_mag, op2_mag;

  // Only MULH/MULHSU treat rs1 as signed; only MULH treats rs2 as signed.
  always_comb begin
    op1_neg = (bus.mode == 2'b01 || bus.mode == 2'b10) && bus.operand_1[WIDTH-1];
    op2_neg = (bus.mode == 2'b01) && bus.operand_2[WIDTH-1];
    op1_mag = op1_neg ? ('0 - bus.operand_1) : bus.operand_1;
    op2_mag = op2_neg ? ('0 - bus.operand_2) : bus.operand_2;
  end

  always_comb begin
    state_d  = state_q;
    mode_d   = mode_q;
    acc_d    = acc_q;
    mcand_d  = mcand_q;
    mplier_d = mplier_q;
    count_d  = count_q;
    neg_d    = neg_q;
    result_d = result_q;
    busy_d   = busy_q;
    done_d   = done_q;

    // Everything, including a pending done pulse, holds while enable is low.
    if (bus.enable) begin
      done_d = 1'b0;
      case (state_q)
        S_IDLE: begin
          if (bus.start) begin
            mode_d   = bus.mode;
            mcand_d  = {{WIDTH{1'b0}}, op1_mag};
            mplier_d = op2_mag;
            neg_d    = op1_neg ^ op2_neg;
            acc_d    = '0;
            count_d  = CNT_W'(WIDTH);
            busy_d   = 1'b1;
            state_d  = S_CALC;
          end
        end
        S_CALC: begin
          if (mplier_q[0]) acc_d = acc_q + mcand_q;
          mcand_d  = mcand_q << 1;
          mplier_d = mplier_q >> 1;
          count_d  = count_q - CNT_W'(1);
`ifdef SEQ_MUL_EARLY_OUT_EN
          if (count_d == '0 || mplier_d == '0) state_d = S_FIX;
`else
          if (count_d == '0) state_d = S_FIX;
`endif
        end
        S_FIX: begin
          if (neg_q) acc_d = '0 - acc_q;
          state_d = S_DONE;
        end
        S_DONE: begin
          result_d = (mode_q == 2'b00) ? acc_q[WIDTH-1:0] : acc_q[2*WIDTH-1:WIDTH];
          done_d   = 1'b1;
          busy_d   = 1'b0;
          state_d  = S_IDLE;
        end
        default: state_d = S_IDLE;
      endcase
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q  <= S_IDLE;
      mode_q   <= '0;
      acc_q    <= '0;
      mcand_q  <= '0;
      mplier_q <= '0;
      count_q  <= '0;
      neg_q    <= 1'b0;
      result_q <= '0;
      busy_q   <= 1'b0;
      done_q   <= 1'b0;
    end else begin
      state_q  <= state_d;
      mode_q   <= mode_d;
      acc_q    <= acc_d;
      mcand_q  <= mcand_d;
      mplier_q <= mplier_d;
      count_q  <= count_d;
      neg_q    <= neg_d;
      result_q <= result_d;
      busy_q   <= busy_d;
      done_q   <= done_d;
    end
  end

  assign bus.result = result_q;
  assign bus.busy   = busy_q;
  assign bus.done   = done_q;
endmodule

// File: tb/tb_seq_multiplier.sv
// Scoreboard bench for seq_multiplier: expected products/latencies queued at start, checked at done.
module tb_seq_multiplier;
  localparam int W = 32;

  logic clk = 1'b0;
  logic rst = 1'b1;
  int   n_vec  = 0;
  int   n_fail = 0;

  logic [W-1:0] exp_q[$];
  int           lat_q[$];

  seq_multiplier_if #(.WIDTH(W)) sb ();

  seq_multiplier #(.WIDTH(W)) dut (
    .clk (clk),
    .rst (rst),
    .bus (sb)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // Reference: widen both operands with the proper signedness and multiply mod 2^(2W+2).
  function automatic logic [W-1:0] ref_mul(input logic [1:0] m, input logic [W-1:0] a,
                                           input logic [W-1:0] b);
    logic [2*W+1:0] ea, eb, p;
    ea = (m == 2'b01 || m == 2'b10) ? {{(W+2){a[W-1]}}, a} : {{(W+2){1'b0}}, a};
    eb = (m == 2'b01) ? {{(W+2){b[W-1]}}, b} : {{(W+2){1'b0}}, b};
    p  = ea * eb;
    return (m == 2'b00) ? p[W-1:0] : p[2*W-1:W];
  endfunction

  function automatic int exp_lat(input logic [1:0] m, input logic [W-1:0] b);
`ifdef SEQ_MUL_EARLY_OUT_EN
    logic [W-1:0] mag;
    int bl;
    mag = (m == 2'b01 && b[W-1]) ? (~b + 32'd1) : b;
    bl = 0;
    for (int i = 0; i < W; i++) if (mag[i]) bl = i + 1;
    return ((bl < 1) ? 1 : bl) + 2;
`else
    return W + 2;
`endif
  endfunction

  // Drives start for one edge, then scrambles inputs to prove they are sampled once.
  task automatic start_op(input logic [1:0] m, input logic [W-1:0] a, input logic [W-1:0] b);
    sb.start = 1'b1;
    sb.mode = m;
    sb.operand_1 = a;
    sb.operand_2 = b;
    exp_q.push_back(ref_mul(m, a, b));
    lat_q.push_back(exp_lat(m, b));
    @(posedge clk);
    #1;
    sb.start = 1'b0;
    sb.mode = 2'($urandom);
    sb.operand_1 = $urandom;
    sb.operand_2 = $urandom;
  endtask

  task automatic wait_done(input string tag, input int stall_at, input int stall_len,
                           input int restart_at, input bit chk_end);
    int cyc;
    logic [W-1:0] e;
    int l;
    cyc = 0;
    while (sb.done !== 1'b1 && cyc < 500) begin
      @(posedge clk);
      #1;
      cyc++;
      if (cyc == 1) check({tag, "_busy_c1"}, 64'(sb.busy), 64'd1);
      if (stall_at > 0 && cyc == stall_at) sb.enable = 1'b0;
      if (stall_at > 0 && cyc == stall_at + stall_len) sb.enable = 1'b1;
      if (cyc == restart_at - 1) begin
        sb.start = 1'b1;
        sb.mode = 2'($urandom);
        sb.operand_1 = $urandom;
        sb.operand_2 = $urandom;
      end else begin
        sb.start = 1'b0;
      end
    end
    if (cyc >= 500) begin
      check({tag, "_timeout"}, 64'd0, 64'd1);
      sb.enable = 1'b1;
      return;
    end
    e = exp_q.pop_front();
    l = lat_q.pop_front();
    check({tag, "_result"}, 64'(sb.result), 64'(e));
    check({tag, "_latency"}, 64'(cyc), 64'(l + stall_len));
    check({tag, "_busy_at_done"}, 64'(sb.busy), 64'd0);
    if (chk_end) begin
      @(posedge clk);
      #1;
      check({tag, "_done_pulse"}, 64'(sb.done), 64'd0);
    end
  endtask

  task automatic run(input string tag, input logic [1:0] m, input logic [W-1:0] a,
                     input logic [W-1:0] b);
    start_op(m, a, b);
    wait_done(tag, 0, 0, 0, 1'b1);
  endtask

  logic [W-1:0] pick_a, pick_b;
  logic [W-1:0] specials[6];

  initial begin
    sb.enable = 1'b1;
    sb.start = 1'b0;
    sb.mode = 2'b00;
    sb.operand_1 = '0;
    sb.operand_2 = '0;
    specials[0] = 32'h0000_0000;
    specials[1] = 32'h0000_0001;
    specials[2] = 32'hFFFF_FFFF;
    specials[3] = 32'h8000_0000;
    specials[4] = 32'h7FFF_FFFF;
    specials[5] = 32'h0000_0002;

    repeat (2) @(posedge clk);
    #1;
    check("rst_busy", 64'(sb.busy), 64'd0);
    check("rst_done", 64'(sb.done), 64'd0);
    check("rst_result", 64'(sb.result), 64'd0);
    rst = 1'b0;
    @(posedge clk);
    #1;

    run("mul_7x6", 2'b00, 32'd7, 32'd6);
    run("mulh_min_min", 2'b01, 32'h8000_0000, 32'h8000_0000);
    run("mulh_m1x2", 2'b01, 32'hFFFF_FFFF, 32'h0000_0002);
    run("mulhsu_ff", 2'b10, 32'hFFFF_FFFF, 32'hFFFF_FFFF);
    run("mulhu_ff", 2'b11, 32'hFFFF_FFFF, 32'hFFFF_FFFF);
    run("mul_ff", 2'b00, 32'hFFFF_FFFF, 32'hFFFF_FFFF);

    start_op(2'b01, 32'h1234_5678, 32'hFEDC_BA98);
    wait_done("restart_ignored", 0, 0, 5, 1'b1);

    start_op(2'b10, 32'h8765_4321, 32'h0BAD_F00D);
    wait_done("stall10", 10, 10, 0, 1'b1);

    start_op(2'b11, 32'hDEAD_BEEF, 32'hCAFE_F00D);
    wait_done("done_hold", 0, 0, 0, 1'b0);
    sb.enable = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    check("done_hold_done", 64'(sb.done), 64'd1);
    check("done_hold_result", 64'(sb.result), 64'(ref_mul(2'b11, 32'hDEAD_BEEF, 32'hCAFE_F00D)));
    sb.enable = 1'b1;
    @(posedge clk);
    #1;
    check("done_hold_release", 64'(sb.done), 64'd0);

    start_op(2'b00, 32'h0001_0003, 32'h0000_0105);
    wait_done("b2b_first", 0, 0, 0, 1'b0);
    start_op(2'b01, 32'hFFFF_FFF9, 32'h0000_0006);
    wait_done("b2b_second", 0, 0, 0, 1'b1);

    start_op(2'b01, 32'h7654_3210, 32'h8000_0001);
    repeat (11) @(posedge clk);
    #3;
    rst = 1'b1;
    #1;
    check("midrst_busy", 64'(sb.busy), 64'd0);
    check("midrst_done", 64'(sb.done), 64'd0);
    check("midrst_result", 64'(sb.result), 64'd0);
    void'(exp_q.pop_front());
    void'(lat_q.pop_front());
    @(negedge clk);
    rst = 1'b0;
    @(posedge clk);
    #1;
    check("midrst_no_done", 64'(sb.done), 64'd0);
    run("after_rst", 2'b10, 32'hF000_000F, 32'h0000_1001);

    run("mulhu_5x2", 2'b11, 32'd5, 32'd2);
    run("mul_5x2", 2'b00, 32'd5, 32'd2);
    run("op2_zero", 2'b01, 32'h8000_0000, 32'd0);
    run("mulh_b_neg", 2'b01, 32'd3, 32'hFFFF_FFFF);

    for (int v = 0; v < 1000; v++) begin
      pick_a = ($urandom_range(3) == 0) ? specials[$urandom_range(5)] : 32'($urandom);
      pick_b = ($urandom_range(3) == 0) ? specials[$urandom_range(5)] : 32'($urandom);
      if ($urandom_range(3) == 0) pick_b = pick_b >> $urandom_range(31);
      start_op(2'($urandom), pick_a, pick_b);
      wait_done("rand", 0, 0, 0, 1'b0);
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_fail);
    $finish;
  end
endmodule
